// File: rtl/kadai3_acc.sv
// kadai3_acc: drains 16-bit products from an upstream read-latency-1 FIFO
// and accumulates every N of them into one block sum (block dot-product).
// The completed sum is offered on SUM/SUM_VALID/SUM_READY, and reading
// from the FIFO stops until the consumer has taken that sum.
//
// Handshake rules for SUM:
//   SUM_VALID is registered. Once it rises, SUM and SUM_VALID stay stable
//   until a rising CLK edge with SUM_VALID=1 and SUM_READY=1 transfers the
//   word. SUM_READY may be high before SUM_VALID rises. RD never depends
//   on SUM_READY, so there is no combinational path from ready to read.
module kadai3_acc #(
  parameter int N    = 8,
  parameter int ACCW = 24
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [15:0]     DIN,
  input  logic            VALID,
  input  logic            EMPTY,
  output logic            RD,
  output logic [ACCW-1:0] SUM,
  output logic            SUM_VALID,
  input  logic            SUM_READY,
  output logic            ERR,
  output logic            dbg_state
);

  // Both counters must be able to hold the value N.
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [ACCW-1:0] acc, acc_nxt;
  logic [ACCW-1:0] sum_nxt;
  logic            sum_valid_nxt;
  logic            err_nxt;
  logic [CW-1:0]   issued, issued_nxt;
  logic [CW-1:0]   got, got_nxt;

  logic [ACCW-1:0] din_ext;
  logic [ACCW-1:0] acc_plus;
  logic            accept;
  logic            unsolicited;

  // The product is zero-extended. The sum wraps modulo 2^ACCW.
  assign din_ext  = {{(ACCW-16){1'b0}}, DIN};
  assign acc_plus = acc + din_ext;

  // Reads are issued only while collecting and while fewer than N reads are
  // in this block. RST is part of the term so RD is low during reset.
  assign RD = RST && (state == ST_ACC) && !EMPTY && (issued < N_C);

  // A VALID word belongs to this block only if it answers an outstanding read.
  assign accept      = (state == ST_ACC) && VALID && (issued > got);
  assign unsolicited = VALID && !accept;

  assign dbg_state = state;

  // Next-state, counter, accumulator and result logic.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    sum_nxt       = SUM;
    sum_valid_nxt = SUM_VALID;
    err_nxt       = ERR;
    issued_nxt    = issued;
    got_nxt       = got;

    if (RD) begin
      issued_nxt = issued + 1'b1;
    end

    case (state)
      ST_ACC: begin
        if (accept) begin
          if (got == LAST_C) begin
            // The Nth word completes the block. At this point issued == N,
            // so RD is low and clearing issued does not drop a read.
            sum_nxt       = acc_plus;
            sum_valid_nxt = 1'b1;
            state_nxt     = ST_HOLD;
            acc_nxt       = '0;
            got_nxt       = '0;
            issued_nxt    = '0;
          end else begin
            acc_nxt = acc_plus;
            got_nxt = got + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (SUM_VALID && SUM_READY) begin
          sum_valid_nxt = 1'b0;
          state_nxt     = ST_ACC;
        end
      end
      default: begin
        state_nxt = ST_ACC;
      end
    endcase

    // The data of an unsolicited word is dropped. The error flag is sticky.
    if (unsolicited) begin
      err_nxt = 1'b1;
    end
  end

  // State registers. Reset discards any partial block and any pending result.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_ACC;
      acc       <= '0;
      SUM       <= '0;
      SUM_VALID <= 1'b0;
      ERR       <= 1'b0;
      issued    <= '0;
      got       <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      SUM       <= sum_nxt;
      SUM_VALID <= sum_valid_nxt;
      ERR       <= err_nxt;
      issued    <= issued_nxt;
      got       <= got_nxt;
    end
  end

endmodule

// File: doc/kadai3_acc.md
# kadai3_acc

Downstream consumer of the multiply pipeline's output FIFO. Drains 16-bit products through the FIFO's RD/VALID/EMPTY interface and accumulates groups of N products into one sum (block dot-product). Presents each completed sum on a valid/ready output handshake. Applies back-pressure to the FIFO by withholding RD while a result is unaccepted.

## Interface
- N, default 8: products per accumulated block, N ≥ 2.
- ACCW, default 24: accumulator/result width, ACCW ≥ 16 + clog2(N).

- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- DIN  in  16  product word from the upstream FIFO DOUT.
- VALID  in  1  upstream FIFO read data valid; DIN is meaningful only when VALID=1.
- EMPTY  in  1  upstream FIFO empty.
- RD  out  1  read strobe to the upstream FIFO; combinational.
- SUM  out  ACCW  completed block sum; registered.
- SUM_VALID  out  1  SUM holds a completed block; registered.
- SUM_READY  in  1  consumer accepts SUM.
- ERR  out  1  sticky protocol error flag; registered.

## Operation
- Two states: ACC (collecting products) and HOLD (result waiting for consumer).
- Counters: `issued` counts RD pulses in the current block (0..N); `got` counts accepted VALID words (0..N-1).
- Accumulator `acc` is ACCW bits wide; DIN is zero-extended. Addition wraps modulo 2^ACCW with no saturation.
- RD = (state==ACC) && !EMPTY && (issued < N). No reads are issued beyond N per block. No reads are issued in HOLD.
- In ACC, when VALID=1 and `issued` > `got`:
  - If `got` < N-1: acc ← acc + DIN and got ← got + 1.
  - If `got` == N-1: SUM ← acc + DIN, SUM_VALID ← 1, state ← HOLD, and acc, got, issued ← 0.
- VALID=1 while `issued` == `got` (no outstanding read), or VALID=1 in HOLD, is unsolicited:
  - The data is ignored.
  - ERR ← 1, held until reset.
- In HOLD, when SUM_VALID && SUM_READY at a rising edge: SUM_VALID ← 0 and state ← ACC. SUM keeps its last value.
- EMPTY gaps suspend reading only. Partial accumulation is retained across any number of idle cycles.
- Reset (RST=0), asynchronous, including mid-block or in HOLD:
  - State ← ACC; acc, issued, got ← 0.
  - SUM ← 0, SUM_VALID ← 0, ERR ← 0.
  - RD evaluates to 0 while RST=0.
  - Any partial block is discarded. The upstream FIFO shares RST, so no stale VALID arrives after release.

## Timing
- The upstream FIFO has read latency 1: RD high in cycle t gives VALID/DIN in cycle t+1.
- Throughput: one product per cycle when EMPTY=0 continuously.
- A block of N products with no gaps:
  - RD is high in cycles 0..N-1.
  - VALID is high in cycles 1..N.
  - SUM_VALID=1 from cycle N+1.
- Result latency: SUM_VALID rises on the clock edge after the Nth VALID cycle.
- HOLD duration is unbounded. RD=0 throughout, and SUM is stable while SUM_VALID=1.
- SUM_READY may already be high when SUM_VALID rises. The handshake then completes in that first cycle, and RD may reassert in the following cycle.
- Minimum inter-block period: N+2 cycles, because no reads are pipelined across HOLD.

## Test plan
- N=4, FIFO preloaded with products 1,2,3,4, SUM_READY=1 -> RD high 4 cycles; SUM=10 with SUM_VALID=1 one cycle after the 4th VALID, for 1 cycle; then RD resumes.
- N=8, eight products of 0xFE01 -> SUM=0x07F008, no wrap, ERR=0.
- SUM_READY low for 5 cycles after SUM_VALID, FIFO non-empty -> RD=0 and SUM/SUM_VALID unchanged for all 5 cycles; one cycle after SUM_READY rises, SUM_VALID=0 and RD=1.
- EMPTY toggling every other cycle during a block of 1..4 -> same SUM=10; completion only after the 4th VALID.
- VALID pulsed with no prior RD (DIN=0x1234) -> ERR=1 sticky, next block sum excludes 0x1234.
- RST low for 1 cycle after 2 of 4 products -> SUM=0, SUM_VALID=0, ERR=0 immediately; next block 5,5,5,5 gives SUM=20.
